tm1638_spi_target: RTL and testbench

- Target (device) end of the 3-wire TM1638-style serial link driven by the team's SPI master. Used as a synthesizable device emulator and as a bench responder.
- Oversamples STB/CLK/DIO with the system clock and deserializes LSB-first bytes while STB is low.
- Presents each received byte on a valid strobe.
- When the first byte of a frame equals READ_CMD, it drives READ_WIDTH key-scan bits back on DIO, LSB first.

---
 rtl/tm1638_pkg.sv | 15 +
 rtl/tm1638_spi_target_if.sv | 27 ++
 rtl/sync_edge.sv | 34 +++
 rtl/tm1638_spi_target.sv | 163 ++++++++++++++++
 tb/tb_tm1638_spi_target.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638-style serial target.
// Latency: none (types and constants only).
package tm1638_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TM1638_CMD_READ_KEYS = 8'h42;
  localparam int         BYTE_W               = 8;

endpackage

// File: rtl/tm1638_spi_target_if.sv
// Parallel side of the serial target: received bytes out, key-scan data in.
// slave = the target itself; master = whatever consumes bytes and supplies scan data.
interface tm1638_spi_target_if
  import tm1638_pkg::*;
#(
  parameter int READ_WIDTH = 32
);

  logic                  byte_vld;
  logic [BYTE_W-1:0]     byte_dat;
  logic                  byte_is_cmd;
  logic                  frame_active;
  logic                  read_done;
  logic                  frame_error;
  logic [READ_WIDTH-1:0] read_dat;

  modport slave (
    output byte_vld, byte_dat, byte_is_cmd, frame_active, read_done, frame_error,
    input  read_dat
  );

  modport master (
    input  byte_vld, byte_dat, byte_is_cmd, frame_active, read_done, frame_error,
    output read_dat
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a reset preset level, plus rise/fall detect on the synced value.
// Latency: STAGES cycles to level, edges flagged in the same cycle the synced level changes.
module sync_edge #(
  parameter int   STAGES = 2,
  parameter logic PRESET = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic sync_in,
  output logic level,
  output logic level_d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              level_d_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q    <= {STAGES{PRESET}};
      level_d_q <= PRESET;
    end else begin
      sync_q    <= {sync_q[STAGES-2:0], sync_in};
      level_d_q <= sync_q[STAGES-1];
    end
  end

  assign level   = sync_q[STAGES-1];
  assign level_d = level_d_q;
  assign rise    = level & ~level_d_q;
  assign fall    = ~level & level_d_q;

endmodule

// File: rtl/tm1638_spi_target.sv
// Device end of the 3-wire STB/CLK/DIO link: deserializes LSB-first bytes, answers READ_CMD with scan bits.
// Latency: byte strobe SYNC_STAGES+1 cycles after the 8th raw CLK rise; read bit on DIO SYNC_STAGES+1 after raw CLK fall.
module tm1638_spi_target
  import tm1638_pkg::*;
#(
  parameter int         READ_WIDTH  = 32,
  parameter logic [7:0] READ_CMD    = TM1638_CMD_READ_KEYS,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_SPI_Stb,
  input  logic                   i_SPI_Clk,
  inout  wire                    io_SPI_Dio,
  tm1638_spi_target_if.slave     bus
);

  localparam int CNT_W = $clog2(BYTE_W);
  localparam int IDX_W = $clog2(READ_WIDTH) + 1;

  logic stb_lvl, stb_rise, stb_fall, stb_lvl_d_unused;
  logic clk_rise, clk_fall, clk_lvl_unused, clk_lvl_d_unused;
  logic dio_lvl, dio_lvl_d_unused, dio_rise_unused, dio_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_stb (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .sync_in(i_SPI_Stb),
    .level(stb_lvl), .level_d(stb_lvl_d_unused), .rise(stb_rise), .fall(stb_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_clk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .sync_in(i_SPI_Clk),
    .level(clk_lvl_unused), .level_d(clk_lvl_d_unused), .rise(clk_rise), .fall(clk_fall)
  );

  // Same depth as CLK so the sampled DIO lines up with the detected CLK rise.
  sync_edge #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_dio (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .sync_in(io_SPI_Dio),
    .level(dio_lvl), .level_d(dio_lvl_d_unused), .rise(dio_rise_unused), .fall(dio_fall_unused)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  first_q;
  logic [BYTE_W-2:0]     rx_sh_q;
  logic [BYTE_W-1:0]     byte_q;
  logic [READ_WIDTH-1:0] tx_sh_q;
  logic [IDX_W-1:0]      tx_idx_q;
  logic                  dio_oe_q, dio_bit_q;
  logic                  byte_vld_q, is_cmd_q, read_done_q, frame_err_q;

  logic [BYTE_W-1:0] rx_byte;
  logic              tx_all_sent;
  logic              start_frame, rx_bit, byte_done, load_tx;
  logic              tx_bit, tx_end, frame_err, dio_release;

  assign rx_byte     = {dio_lvl, rx_sh_q};
  assign tx_all_sent = (tx_idx_q == IDX_W'(READ_WIDTH));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (stb_fall) state_d = ST_RX;
      ST_RX: begin
        if (stb_rise)     state_d = ST_IDLE;
        else if (load_tx) state_d = ST_TX;
      end
      ST_TX: begin
        if (stb_rise)    state_d = ST_IDLE;
        else if (tx_end) state_d = ST_DONE;
      end
      ST_DONE: if (stb_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // STB rise wins over any CLK edge detected in the same cycle.
  always_comb begin
    start_frame = 1'b0;
    rx_bit      = 1'b0;
    byte_done   = 1'b0;
    load_tx     = 1'b0;
    tx_bit      = 1'b0;
    tx_end      = 1'b0;
    frame_err   = 1'b0;
    dio_release = 1'b0;
    unique case (state_q)
      ST_IDLE: start_frame = stb_fall;
      ST_RX: begin
        frame_err = stb_rise && (bit_cnt_q != '0);
        rx_bit    = clk_rise && !stb_rise;
        byte_done = rx_bit && (bit_cnt_q == CNT_W'(BYTE_W - 1));
        load_tx   = byte_done && first_q && (rx_byte == READ_CMD);
      end
      ST_TX: begin
        frame_err   = stb_rise && !tx_all_sent;
        tx_bit      = clk_fall && !stb_rise && !tx_all_sent;
        tx_end      = clk_rise && !stb_rise && tx_all_sent;
        dio_release = stb_rise || tx_end;
      end
      ST_DONE: dio_release = 1'b1;
      default: dio_release = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      rx_sh_q     <= '0;
      byte_q      <= '0;
      tx_sh_q     <= '0;
      tx_idx_q    <= '0;
      dio_oe_q    <= 1'b0;
      dio_bit_q   <= 1'b0;
      byte_vld_q  <= 1'b0;
      is_cmd_q    <= 1'b0;
      read_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= byte_done;
      is_cmd_q    <= byte_done && first_q;
      read_done_q <= tx_end;
      frame_err_q <= frame_err;
      if (start_frame) begin
        bit_cnt_q <= '0;
        first_q   <= 1'b1;
      end
      if (rx_bit) begin
        rx_sh_q   <= {dio_lvl, rx_sh_q[BYTE_W-2:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (byte_done) begin
        byte_q  <= rx_byte;
        first_q <= 1'b0;
      end
      if (load_tx) begin
        tx_sh_q  <= bus.read_dat;
        tx_idx_q <= '0;
      end
      if (tx_bit) begin
        dio_bit_q <= tx_sh_q[tx_idx_q[IDX_W-2:0]];
        dio_oe_q  <= 1'b1;
        tx_idx_q  <= tx_idx_q + 1'b1;
      end
      if (dio_release) dio_oe_q <= 1'b0;
    end
  end

  assign io_SPI_Dio = dio_oe_q ? dio_bit_q : 1'bz;

  assign bus.byte_vld     = byte_vld_q;
  assign bus.byte_dat     = byte_q;
  assign bus.byte_is_cmd  = is_cmd_q;
  assign bus.frame_active = ~stb_lvl;
  assign bus.read_done    = read_done_q;
  assign bus.frame_error  = frame_err_q;

endmodule

// File: tb/tb_tm1638_spi_target.sv
// Bench for tm1638_spi_target: a bit-banged master drives frames; results are set against a frame-level model.
module tb_tm1638_spi_target;
  import tm1638_pkg::*;

  localparam int RW = 32;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  logic spi_stb = 1'b1;
  logic spi_clk = 1'b1;
  logic tb_oe = 1'b0;
  logic tb_bit = 1'b0;
  wire  dio_w;

  assign dio_w = tb_oe ? tb_bit : 1'bz;

  tm1638_spi_target_if #(.READ_WIDTH(RW)) bus();

  tm1638_spi_target #(.READ_WIDTH(RW), .READ_CMD(TM1638_CMD_READ_KEYS), .SYNC_STAGES(2)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_Stb(spi_stb), .i_SPI_Clk(spi_clk),
    .io_SPI_Dio(dio_w), .bus(bus)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail = 0;
  int half = 4;

  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  int rx_ptr = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int contention = 0;
  int oe_cycles = 0;

  always @(negedge i_Clk) begin
    if (bus.byte_vld) rx_q.push_back({bus.byte_is_cmd, bus.byte_dat});
    if (bus.read_done) done_cnt++;
    if (bus.frame_error) err_cnt++;
    if (tb_oe && dut.dio_oe_q) contention++;
    if (dut.dio_oe_q) oe_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic stb_low();
    spi_stb = 1'b0;
    tick(half);
  endtask

  task automatic stb_high(input int gap);
    tb_oe = 1'b0;
    tick(half);
    spi_stb = 1'b1;
    tick(gap);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_clk = 1'b0;
      tb_oe   = 1'b1;
      tb_bit  = b[i];
      tick(half);
      spi_clk = 1'b1;
      tick(half);
    end
  endtask

  // Sends READ_CMD, pauses with CLK high, swaps the scan input, then clocks nbits back.
  task automatic do_read(input logic [31:0] data, input int nbits, output logic [31:0] got);
    bus.read_dat = data;
    stb_low();
    send_bits(TM1638_CMD_READ_KEYS, 8);
    tb_oe = 1'b0;
    tick(2 * half + 2);
    bus.read_dat = ~data;
    chk("read_oe_before_fall", {31'd0, dut.dio_oe_q}, 32'd0);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      tick(half);
      got[i] = dio_w;
      spi_clk = 1'b1;
      tick(half);
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, rx_q.size() - rx_ptr, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (rx_ptr + k < rx_q.size())
        chk({tag, "_byte"}, {23'd0, rx_q[rx_ptr + k]}, {23'd0, exp_q[k]});
    rx_ptr = rx_q.size();
    exp_q.delete();
  endtask

  initial begin
    int base_err, base_done, base_oe, nbytes;
    logic [31:0] got, rdata;
    logic [7:0] b, cmd;
    logic [7:0] frame[$];

    bus.read_dat = '0;
    tick(4);
    chk("rst_oe", {31'd0, dut.dio_oe_q}, 32'd0);
    chk("rst_byte_vld", {31'd0, bus.byte_vld}, 32'd0);
    chk("rst_byte_dat", {24'd0, bus.byte_dat}, 32'd0);
    chk("rst_is_cmd", {31'd0, bus.byte_is_cmd}, 32'd0);
    chk("rst_frame_active", {31'd0, bus.frame_active}, 32'd0);
    chk("rst_read_done", {31'd0, bus.read_done}, 32'd0);
    chk("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
    i_Rst = 1'b0;
    tick(4);

    // Write with one data byte
    base_oe = oe_cycles; base_err = err_cnt;
    stb_low(); send_bits(8'h44, 8); send_bits(8'hA5, 8); stb_high(6);
    exp_q.push_back({1'b1, 8'h44}); exp_q.push_back({1'b0, 8'hA5});
    check_rx("wr_data");
    chk("wr_data_no_drive", oe_cycles - base_oe, 0);
    chk("wr_data_no_err", err_cnt - base_err, 0);

    // Write without data
    stb_low(); send_bits(8'h8F, 8);
    tick(4);
    chk("wr_cmd_active_mid", {31'd0, bus.frame_active}, 32'd1);
    stb_high(6);
    chk("wr_cmd_active_after", {31'd0, bus.frame_active}, 32'd0);
    chk("wr_cmd_held", {24'd0, bus.byte_dat}, 32'h8F);
    exp_q.push_back({1'b1, 8'h8F});
    check_rx("wr_cmd");

    // Full read
    base_done = done_cnt; base_err = err_cnt;
    do_read(32'hDEADBEEF, RW, got);
    chk("rd_data", got, 32'hDEADBEEF);
    chk("rd_oe_after_last", {31'd0, dut.dio_oe_q}, 32'd0);
    stb_high(6);
    chk("rd_done_once", done_cnt - base_done, 1);
    chk("rd_no_err", err_cnt - base_err, 0);
    exp_q.push_back({1'b1, 8'h42});
    check_rx("rd");

    // Abort after five bits, then a clean frame
    base_err = err_cnt;
    stb_low(); send_bits(8'h5A, 5); stb_high(6);
    chk("abort_err_once", err_check_delta(base_err), 1);
    check_rx("abort");
    stb_low(); send_bits(8'h40, 8); stb_high(6);
    exp_q.push_back({1'b1, 8'h40});
    check_rx("after_abort");

    // Reset after ten read bits
    base_done = done_cnt; base_err = err_cnt;
    do_read(32'h13579BDF, 10, got);
    chk("rst_rd_partial", {22'd0, got[9:0]}, {22'd0, 10'h3DF});
    i_Rst = 1'b1;
    tick(1);
    chk("rstmid_oe", {31'd0, dut.dio_oe_q}, 32'd0);
    chk("rstmid_frame_active", {31'd0, bus.frame_active}, 32'd0);
    chk("rstmid_byte_dat", {24'd0, bus.byte_dat}, 32'd0);
    spi_stb = 1'b1; spi_clk = 1'b1;
    tick(3);
    i_Rst = 1'b0;
    tick(4);
    chk("rstmid_no_done", done_cnt - base_done, 0);
    chk("rstmid_no_err", err_cnt - base_err, 0);
    exp_q.push_back({1'b1, 8'h42});
    check_rx("rstmid");
    do_read(32'hCAFEF00D, RW, got);
    stb_high(6);
    chk("rstmid_fresh_read", got, 32'hCAFEF00D);
    exp_q.push_back({1'b1, 8'h42});
    check_rx("rstmid_fresh");

    // Back-to-back read then write with a one-cycle STB-high gap
    base_err = err_cnt;
    b = 8'($urandom);
    do_read(32'h0F1E2D3C, RW, got);
    spi_stb = 1'b1; tick(1);
    spi_stb = 1'b0; tick(half);
    send_bits(8'h44, 8); send_bits(b, 8); stb_high(6);
    chk("b2b_read", got, 32'h0F1E2D3C);
    chk("b2b_no_err", err_cnt - base_err, 0);
    exp_q.push_back({1'b1, 8'h42}); exp_q.push_back({1'b1, 8'h44}); exp_q.push_back({1'b0, b});
    check_rx("b2b");

    // Random frames against the frame-level model
    for (int f = 0; f < 6; f++) begin
      half = $urandom_range(4, 6);
      base_err = err_cnt; base_done = done_cnt;
      if ($urandom_range(0, 1) == 0) begin
        rdata = $urandom;
        do_read(rdata, RW, got);
        stb_high(6);
        chk("rnd_read", got, rdata);
        chk("rnd_read_done", done_cnt - base_done, 1);
        exp_q.push_back({1'b1, TM1638_CMD_READ_KEYS});
      end else begin
        nbytes = $urandom_range(1, 4);
        frame.delete();
        cmd = 8'($urandom);
        if (cmd == TM1638_CMD_READ_KEYS) cmd = 8'h43;
        frame.push_back(cmd);
        for (int k = 1; k < nbytes; k++) frame.push_back(8'($urandom));
        stb_low();
        foreach (frame[k]) begin
          send_bits(frame[k], 8);
          exp_q.push_back({k == 0, frame[k]});
        end
        stb_high($urandom_range(1, 4));
        tick(6);
        chk("rnd_write_no_done", done_cnt - base_done, 0);
      end
      chk("rnd_no_err", err_cnt - base_err, 0);
      check_rx("rnd");
    end

    chk("no_contention", contention, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int err_check_delta(input int base);
    return err_cnt - base;
  endfunction

endmodule
